// File: rtl/grid_rmw_sched_pkg.sv
// Shared types for the charge-grid read-modify-write scheduler: cell addresses,
// charge words, scoreboard entries, FSM states and saturating add.
package grid_rmw_sched_pkg;

  localparam int unsigned AW     = 4;   // bits per grid coordinate
  localparam int unsigned CWIDTH = 16;  // charge word width
  localparam int unsigned PINT   = 4;   // corners per deposit

  typedef struct packed {
    logic [AW-1:0] y;
    logic [AW-1:0] x;
  } addr_t;

  typedef logic signed [CWIDTH-1:0] charge_t;

  localparam charge_t CMAX = {1'b0, {(CWIDTH-1){1'b1}}};
  localparam charge_t CMIN = {1'b1, {(CWIDTH-1){1'b0}}};

  typedef struct packed {
    logic                valid;
    addr_t   [PINT-1:0]  addr;
    charge_t [PINT-1:0]  dq;
  } rmw_entry_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} sched_state_e;

  // Overflow shows as disagreement between the two top bits of the widened sum.
  function automatic charge_t sat_add(input charge_t a, input charge_t b);
    logic [CWIDTH:0] s;
    s = {a[CWIDTH-1], a} + {b[CWIDTH-1], b};
    if (s[CWIDTH] != s[CWIDTH-1]) return s[CWIDTH] ? CMIN : CMAX;
    return s[CWIDTH-1:0];
  endfunction

endpackage

// File: rtl/grid_hazard_sb.sv
// Shift-register scoreboard of in-flight RMWs; flags any overlap between a new
// deposit's corners and a live entry, and exposes the read-issue and data taps.
module grid_hazard_sb
  import grid_rmw_sched_pkg::*;
#(
  parameter int unsigned SB_DEPTH = 7,
  parameter int unsigned TAP      = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  rmw_entry_t    push_entry,
  input  addr_t [3:0]   chk_addr,
  output logic          hazard,
  output logic          empty,
  output addr_t [3:0]   head_addr,
  output rmw_entry_t    tap
);

  rmw_entry_t sb [SB_DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < SB_DEPTH; i++) sb[i] <= '0;
    end else begin
      sb[0] <= push ? push_entry : '0;
      for (int unsigned i = 1; i < SB_DEPTH; i++) sb[i] <= sb[i-1];
    end
  end

  always_comb begin
    hazard = 1'b0;
    empty  = 1'b1;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      if (sb[i].valid) begin
        empty = 1'b0;
        for (int unsigned c = 0; c < 4; c++)
          for (int unsigned k = 0; k < 4; k++)
            if (sb[i].addr[k] == chk_addr[c]) hazard = 1'b1;
      end
    end
  end

  assign head_addr = sb[0].addr;
  assign tap       = sb[TAP];

endmodule

// File: rtl/grid_rmw_sched.sv
// Read-modify-write scheduler for the charge grid_mem: reads four corner cells on
// port A, adds the deposit deltas with saturation, writes back on port B.
module grid_rmw_sched
  import grid_rmw_sched_pkg::*;
#(
  parameter int unsigned MEM_LAT  = 4,
  parameter int unsigned SB_DEPTH = MEM_LAT + 3,
  parameter int unsigned CNTW     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  addr_t [3:0]             in_addr,
  input  logic  [3:0][CWIDTH-1:0] in_dq,
  input  logic                    flush,
  output logic                    flush_done,
  output logic                    busy,
  output logic                    mem_swap_rout,
  output logic  [3:0]             mem_wea,
  output addr_t [3:0]             mem_addra,
  output logic  [3:0]             mem_web,
  output addr_t [3:0]             mem_addrb,
  output logic  [3:0][CWIDTH-1:0] mem_dinb,
  input  logic  [3:0][CWIDTH-1:0] mem_douta,
  output logic  [CNTW-1:0]        dep_count,
  output logic  [CNTW-1:0]        stall_count
);

  sched_state_e state, state_nxt;
  logic         hazard, sb_empty, accept;
  rmw_entry_t   push_entry, tap;

  assign in_ready      = (state != DRAIN) && !hazard && rst;
  assign accept        = in_valid && in_ready;
  assign push_entry    = '{valid: 1'b1, addr: in_addr, dq: in_dq};
  assign mem_swap_rout = rst;
  assign mem_wea       = '0;
  assign busy          = !sb_empty && rst;

  // Entry at index MEM_LAT lines up with mem_douta for the read issued from index 0.
  grid_hazard_sb #(
    .SB_DEPTH (SB_DEPTH),
    .TAP      (MEM_LAT)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .push       (accept),
    .push_entry (push_entry),
    .chk_addr   (in_addr),
    .hazard     (hazard),
    .empty      (sb_empty),
    .head_addr  (mem_addra),
    .tap        (tap)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    flush_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (flush)         state_nxt = DRAIN;
        else if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (flush) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (sb_empty) begin
          state_nxt  = IDLE;
          flush_done = rst;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_web     <= '0;
      mem_addrb   <= '0;
      mem_dinb    <= '0;
      dep_count   <= '0;
      stall_count <= '0;
    end else begin
      mem_web   <= {4{tap.valid}};
      mem_addrb <= tap.addr;
      for (int unsigned i = 0; i < 4; i++)
        mem_dinb[i] <= sat_add(mem_douta[i], tap.dq[i]);
      if (tap.valid) dep_count <= dep_count + 1'b1;
      if (in_valid && hazard && (state != DRAIN)) stall_count <= stall_count + 1'b1;
    end
  end

endmodule
